seg_cmd_ctrl: RTL
=================

# seg_cmd_ctrl

Command sequencer between the SPI slave byte interface and the 7-segment output pins. It decodes a byte-oriented command protocol received over SPI, holds the displayed segment pattern, optionally blinks it, and schedules response bytes back to the SPI shifter for MISO. It sits in the top level between the `spi` instance and `uo_out`.

## Interface
- `ACTIVE_LOW`, 1, 1: `seg_out` is the inverted logical pattern (common-anode display).
- `BLINK_W`, 24, width of the blink prescaler counter; must be ≥ 8.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `cs_active`  in  1  SPI frame active; low aborts any partial command.
- `rx_valid`  in  1  one-cycle pulse, received byte valid.
- `rx_data`  in  8  received byte.
- `seg_out`  out  8  segment drive {dp,g,f,e,d,c,b,a}, registered.
- `tx_data`  out  8  response byte for the SPI shifter.
- `tx_load`  out  1  one-cycle pulse, load `tx_data` into the shifter.
- `err`  out  1  sticky protocol error flag.

One clock; reset is synchronous and active-high; ports named `clk` and `rst`.

## Operation
- Logical segment register `seg_q` (active-high, bit0 = a, bit7 = dp).
- `seg_out = ACTIVE_LOW ? ~shown : shown`, where `shown = blank ? 8'h00 : seg_q`.
- Opcodes, first byte of a command:
  - 0x00 NOP.
  - 0x01 WRITE_RAW: the argument byte goes to `seg_q`.
  - 0x02 WRITE_HEX: `seg_q = {arg[4], hexfont(arg[3:0])}`.
  - 0x03 SET_BLINK: `blink_sel = arg[2:0]`; 0 means blink off.
  - 0x04 READ_SEG: response is `seg_q`.
  - 0x05 READ_STATUS: response is `{err, 4'b0, blink_sel}`; `err` is cleared in the same cycle.
  - Any other opcode: set `err`; no argument consumed.
- FSM states:
  - IDLE: opcode byte → ARG for 0x01–0x03. Otherwise execute and stay in IDLE.
  - ARG: argument byte → execute, then IDLE.
- `cs_active` low in ARG: return to IDLE, discard the opcode, set `err`.
- `cs_active` low and `rx_valid` in the same cycle: the abort wins and the byte is dropped.
- Blink:
  - Free-running counter `cnt[BLINK_W-1:0]`, cleared on every SET_BLINK execute.
  - `blank = (blink_sel != 0) & cnt[BLINK_W-8+blink_sel]`.
  - The counter wraps silently.
- Reset values:
  - `seg_q = 0`, so `seg_out = 8'hFF` when `ACTIVE_LOW = 1`.
  - `blink_sel = 0`, `cnt = 0`, `tx_data = 0`, `tx_load = 0`, `err = 0`, FSM in IDLE.
- Reset mid-command: the FSM returns to IDLE and the partial command is lost.

## Timing
- Write commands: `seg_out` updates the cycle after the `rx_valid` cycle of the argument byte.
- Reads: `tx_load` pulses and `tx_data` is valid the cycle after the `rx_valid` cycle of the opcode. `tx_data` holds until the next read.
- `err` sets the cycle after the offending event.
- Consecutive `rx_valid` pulses on adjacent cycles must be accepted with no stall; there is no backpressure.
- When a READ_STATUS clears `err` in the same cycle an error occurs, the set wins.

## Configuration
- `SEG_BLINK_EN` defined: blink counter and blanking logic are present as above.
- `SEG_BLINK_EN` undefined:
  - No counter; `blank = 0`.
  - SET_BLINK still consumes its argument, so the protocol stays compatible, but `blink_sel` stays 0.
  - READ_STATUS reports `blink_sel = 0`.

## Structure
- Package `seg_ctrl_pkg` holds:
  - Opcode localparams (`OP_NOP` … `OP_READ_STATUS`).
  - FSM state enum (`ST_IDLE`, `ST_ARG`).
  - `hexfont` constant table: 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71.
- Sub-module `seg_hex_decoder`: combinational nibble to 7-bit pattern, built on the package table.

## Test plan
- Reset → `seg_out` = 0xFF, `err` = 0, `tx_load` = 0. Then rx 0x01, 0x3F → `seg_out` = 0xC0 one cycle after the second `rx_valid`.
- rx 0x02, 0x15 → `seg_q` = 0xED, `seg_out` = 0x12. Then rx 0x04 → `tx_load` pulse with `tx_data` = 0xED.
- rx 0x01, then `cs_active` drops before the argument → `seg_out` unchanged, `err` = 1. Then rx 0x05 → `tx_data` = 0x80, then `err` = 0.
- rx 0x7A → `err` = 1, FSM stays in IDLE. Next byte 0x01 is treated as an opcode, not an argument.
- `SEG_BLINK_EN`, `BLINK_W` = 8, `seg_q` = 0x06, rx 0x03, 0x01 → `seg_out` alternates 0xF9 ×2 cycles, 0xFF ×2 cycles, repeating.
- Back-to-back `rx_valid` on consecutive cycles: 0x01, 0x5B, 0x04 → `seg_out` = 0xA4, `tx_data` = 0x5B. Repeat with `SEG_BLINK_EN` undefined: SET_BLINK 0x07 leaves the display static.

Source files
------------

// File: rtl/seg_ctrl_pkg.sv
// Shared opcodes, FSM states and the 7-segment font for the SPI display controller.
package seg_ctrl_pkg;

    localparam logic [7:0] OP_NOP         = 8'h00;
    localparam logic [7:0] OP_WRITE_RAW   = 8'h01;
    localparam logic [7:0] OP_WRITE_HEX   = 8'h02;
    localparam logic [7:0] OP_SET_BLINK   = 8'h03;
    localparam logic [7:0] OP_READ_SEG    = 8'h04;
    localparam logic [7:0] OP_READ_STATUS = 8'h05;

    typedef enum logic {
        ST_IDLE,
        ST_ARG
    } state_e;

    // Segment order {g,f,e,d,c,b,a}; lower-case b and d keep them distinct from 8 and 0.
    localparam logic [6:0] HEXFONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational nibble to 7-segment pattern lookup.
module seg_hex_decoder
    import seg_ctrl_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] pattern_o
);

    assign pattern_o = HEXFONT[nibble_i];

endmodule

// File: rtl/seg_cmd_ctrl.sv
// SPI byte-command sequencer driving a 7-segment display, with optional blink.
// Blink counter and blanking exist only when SEG_BLINK_EN is defined; BLINK_W must be >= 8.
module seg_cmd_ctrl
    import seg_ctrl_pkg::*;
#(
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter int unsigned BLINK_W    = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_active,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [7:0] seg_out,
    output logic [7:0] tx_data,
    output logic       tx_load,
    output logic       err
);

    state_e     state_q, state_d;
    logic [7:0] op_q, op_d;
    logic [7:0] seg_q, seg_d;
    logic [7:0] seg_out_q;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_load_q, tx_load_d;
    logic       err_q, err_d;
    logic       err_set, err_clr;
    logic       blank_d;
    logic [7:0] shown_d;
    logic [6:0] hex_pattern;

    seg_hex_decoder u_hex (
        .nibble_i  (rx_data[3:0]),
        .pattern_o (hex_pattern)
    );

    if (BLINK_W < 8) begin : g_blink_w_too_small
    end

`ifdef SEG_BLINK_EN
    localparam logic [BLINK_W-1:0] CNT_ONE = 1;

    logic               blink_wr;
    logic [2:0]         blink_sel_q, blink_sel_d;
    logic [BLINK_W-1:0] cnt_q, cnt_d;
    logic [7:0]         cnt_top;

    always_comb begin
        blink_sel_d = blink_wr ? rx_data[2:0] : blink_sel_q;
        cnt_d       = blink_wr ? '0 : cnt_q + CNT_ONE;
    end

    // blink_sel picks one of the top seven counter bits; larger values blink slower.
    assign cnt_top = cnt_d[BLINK_W-1 -: 8];
    assign blank_d = (blink_sel_d != 3'd0) && cnt_top[blink_sel_d];

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_sel_q <= 3'd0;
            cnt_q       <= '0;
        end else begin
            blink_sel_q <= blink_sel_d;
            cnt_q       <= cnt_d;
        end
    end
`else
    logic [2:0] blink_sel_q;

    assign blink_sel_q = 3'd0;
    assign blank_d     = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        seg_d     = seg_q;
        tx_data_d = tx_data_q;
        tx_load_d = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;
`ifdef SEG_BLINK_EN
        blink_wr  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // A byte arriving while chip-select is low is dropped.
                if (cs_active && rx_valid) begin
                    case (rx_data)
                        OP_NOP: ;
                        OP_WRITE_RAW, OP_WRITE_HEX, OP_SET_BLINK: begin
                            op_d    = rx_data;
                            state_d = ST_ARG;
                        end
                        OP_READ_SEG: begin
                            tx_data_d = seg_q;
                            tx_load_d = 1'b1;
                        end
                        OP_READ_STATUS: begin
                            tx_data_d = {err_q, 4'b0000, blink_sel_q};
                            tx_load_d = 1'b1;
                            err_clr   = 1'b1;
                        end
                        default: err_set = 1'b1;
                    endcase
                end
            end
            ST_ARG: begin
                if (!cs_active) begin
                    state_d = ST_IDLE;
                    err_set = 1'b1;
                end else if (rx_valid) begin
                    state_d = ST_IDLE;
                    case (op_q)
                        OP_WRITE_RAW: seg_d = rx_data;
                        OP_WRITE_HEX: seg_d = {rx_data[4], hex_pattern};
                        default: begin
`ifdef SEG_BLINK_EN
                            blink_wr = 1'b1;
`endif
                        end
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase

        err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    // Output pins are computed from next-state values so they change with seg_q, not after it.
    assign shown_d = blank_d ? 8'h00 : seg_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_NOP;
            seg_q     <= 8'h00;
            seg_out_q <= ACTIVE_LOW ? 8'hFF : 8'h00;
            tx_data_q <= 8'h00;
            tx_load_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            seg_q     <= seg_d;
            seg_out_q <= ACTIVE_LOW ? ~shown_d : shown_d;
            tx_data_q <= tx_data_d;
            tx_load_q <= tx_load_d;
            err_q     <= err_d;
        end
    end

    assign seg_out = seg_out_q;
    assign tx_data = tx_data_q;
    assign tx_load = tx_load_q;
    assign err     = err_q;

endmodule
